// File: rtl/seg_pkg.sv
// Shared types and helpers for the seven-segment scan controller.
package seg_pkg;

  // Digit index, segment and anode widths for the 8-digit display.
  localparam int IDX_W = 3;
  localparam int SEG_W = 7;
  localparam int AN_W  = 8;

  // Scan sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } scan_state_e;

  // Pin-level "off" value for the anode strobes.
  function automatic logic [AN_W-1:0] an_inactive(input logic active_low);
    logic [AN_W-1:0] v;
    if (active_low) begin
      v = {AN_W{1'b1}};
    end else begin
      v = {AN_W{1'b0}};
    end
    return v;
  endfunction

  // Pin-level "off" value for the segment lines.
  function automatic logic [SEG_W-1:0] seg_inactive(input logic active_low);
    logic [SEG_W-1:0] v;
    if (active_low) begin
      v = {SEG_W{1'b1}};
    end else begin
      v = {SEG_W{1'b0}};
    end
    return v;
  endfunction

  // Mask of the digits that are physically fitted (low n bits set).
  function automatic logic [AN_W-1:0] fit_mask(input int n);
    logic [AN_W-1:0] v;
    v = {AN_W{1'b0}};
    for (int i = 0; i < AN_W; i++) begin
      v[i] = (i < n);
    end
    return v;
  endfunction

  // Active-high one-hot anode vector for a digit index.
  function automatic logic [AN_W-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    logic [AN_W-1:0] one;
    one = {{(AN_W-1){1'b0}}, 1'b1};
    return one << idx;
  endfunction

endpackage

// File: rtl/seg_scan_next_idx.sv
// Circular search for the next enabled digit above the current index.
// With cur_idx = 7 it returns the lowest set bit, which is how a frame
// is started from IDLE. A single enabled digit finds itself and counts
// as a wrap, so every frame start is flagged the same way.
module seg_scan_next_idx
  import seg_pkg::*;
(
  input  logic [AN_W-1:0]  mask,
  input  logic [IDX_W-1:0] cur_idx,
  output logic [IDX_W-1:0] next_idx,
  output logic             wrapped,
  output logic             found
);

  logic [IDX_W-1:0] cand_s;

  // Scan offsets from farthest to nearest so the nearest set bit wins.
  always_comb begin
    next_idx = cur_idx;
    found    = 1'b0;
    cand_s   = cur_idx;
    for (int off = AN_W; off >= 1; off--) begin
      cand_s = cur_idx + IDX_W'(off);
      if (mask[cand_s]) begin
        next_idx = cand_s;
        found    = 1'b1;
      end else begin
        found    = found;
      end
    end
    wrapped = found && (next_idx <= cur_idx);
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for an 8-digit seven-segment display.
// Each enabled digit gets BLANK_CYCLES dark cycles (select settles, no
// ghosting) followed by DIG_CYCLES lit cycles. All outputs are registered.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int DIG_CYCLES   = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [AN_W-1:0]  digit_mask,
  input  logic [SEG_W-1:0] mux_in,
  output logic [IDX_W-1:0] sel,
  output logic [SEG_W-1:0] seg,
  output logic [AN_W-1:0]  an,
  output logic             frame_tick
);

  localparam int CNT_MAX = (DIG_CYCLES > BLANK_CYCLES) ? DIG_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIG_LAST   = CNT_W'(DIG_CYCLES - 1);
  localparam logic [AN_W-1:0]  FIT_MASK   = fit_mask(NUM_DIGITS);
  localparam logic [AN_W-1:0]  AN_OFF     = an_inactive(ACTIVE_LOW != 0);
  localparam logic [SEG_W-1:0] SEG_OFF    = seg_inactive(ACTIVE_LOW != 0);

  scan_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] sel_q, sel_d;
  logic [SEG_W-1:0] seg_q, seg_d;
  logic [AN_W-1:0]  an_q, an_d;
  logic             frame_tick_q, frame_tick_d;

  logic [AN_W-1:0]  eff_mask_s;
  logic [IDX_W-1:0] search_from_s;
  logic [IDX_W-1:0] next_idx_s;
  logic             next_wrapped_s;
  logic             next_found_s;

  // Digits that are both requested and physically fitted.
  assign eff_mask_s = digit_mask & FIT_MASK;

  // From IDLE search from index 7 so the lowest enabled digit is found.
  always_comb begin
    if (state_q == ST_SHOW) begin
      search_from_s = sel_q;
    end else begin
      search_from_s = 3'd7;
    end
  end

  seg_scan_next_idx u_next_idx (
    .mask     (eff_mask_s),
    .cur_idx  (search_from_s),
    .next_idx (next_idx_s),
    .wrapped  (next_wrapped_s),
    .found    (next_found_s)
  );

  // Sequencer: next state, dwell counter, digit select and frame pulse.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    sel_d        = sel_q;
    frame_tick_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        sel_d = 3'd0;
        if (enable && next_found_s) begin
          state_d      = ST_BLANK;
          sel_d        = next_idx_s;
          frame_tick_d = 1'b1;
        end else begin
          state_d      = ST_IDLE;
        end
      end
      ST_BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = ST_SHOW;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      ST_SHOW: begin
        if (cnt_q == DIG_LAST) begin
          cnt_d = '0;
          // The mask is only consulted here, at the digit advance.
          if (next_found_s) begin
            state_d      = ST_BLANK;
            sel_d        = next_idx_s;
            frame_tick_d = next_wrapped_s;
          end else begin
            state_d      = ST_IDLE;
            sel_d        = 3'd0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        sel_d   = 3'd0;
      end
    endcase
    // Dropping enable parks the scan immediately, whatever the state.
    if (!enable) begin
      state_d      = ST_IDLE;
      cnt_d        = '0;
      sel_d        = 3'd0;
      frame_tick_d = 1'b0;
    end else begin
      frame_tick_d = frame_tick_d;
    end
  end

  // Pin drive decoded from the next state so an/seg switch with the state.
  always_comb begin
    if (state_d == ST_SHOW) begin
      an_d  = idx_to_onehot(sel_d) ^ AN_OFF;
      seg_d = mux_in ^ SEG_OFF;
    end else begin
      an_d  = AN_OFF;
      seg_d = SEG_OFF;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      sel_q        <= 3'd0;
      seg_q        <= SEG_OFF;
      an_q         <= AN_OFF;
      frame_tick_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sel_q        <= sel_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign sel        = sel_q;
  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexing scan controller for the 8-digit seven-segment display. It drives the 3-bit select of the 8:1 7-bit digit-pattern multiplexer and registers the selected pattern onto the segment pins. It also generates the one-hot digit-enable (anode) strobes, with a blanking gap between digits to suppress ghosting. It sits between the display-pattern registers/mux and the board pins.

## Interface
Parameters:
- `NUM_DIGITS`, 8: digits physically fitted. Range 1..8; indices ≥ NUM_DIGITS are never selected.
- `DIG_CYCLES`, 50000: clk cycles a digit is lit (SHOW). Must be ≥1.
- `BLANK_CYCLES`, 500: clk cycles all digits are dark before each digit (BLANK). Must be ≥1.
- `ACTIVE_LOW`, 1: 1 means `an`/`seg` are low-true at the pins. Inactive level = all ones when 1, all zeros when 0.

Ports:
- `clk`, in, 1: single clock; all logic on rising edge.
- `rst`, in, 1: reset is synchronous and active-high.
- `enable`, in, 1: scan run; low forces IDLE.
- `digit_mask`, in, 8: bit i=1 means digit i is shown; masked digits are skipped.
- `mux_in`, in, 7: pattern returned by the 8:1 mux for current `sel`.
- `sel`, out, 3: mux select = current digit index.
- `seg`, out, 7: registered segment pattern at pin polarity.
- `an`, out, 8: one-hot digit enable at pin polarity.
- `frame_tick`, out, 1: one-cycle pulse at start of each scan frame.

## Operation
- States: IDLE, BLANK, SHOW. Cycle counter `cnt` sized for max(DIG_CYCLES, BLANK_CYCLES).
- Effective mask `m = digit_mask & ((1<<NUM_DIGITS)-1)`.
- IDLE: `an`, `seg` inactive; `sel`=0; `cnt`=0. Transition to BLANK when `enable`=1 and m≠0. `sel` loads lowest set bit of m and `frame_tick` pulses.
- BLANK: `an`, `seg` inactive; `sel` held. After BLANK_CYCLES cycles go to SHOW.
- SHOW: `an` asserts bit `sel` only; `seg` = `mux_in` registered every cycle, so live pattern updates are shown with 1-cycle latency. After DIG_CYCLES cycles go to BLANK, with `sel` ← next set bit of m above `sel`, wrapping.
- Wrap: if the next index is ≤ current index, a new frame starts. `frame_tick` pulses in the first BLANK cycle of the new frame.
- Single enabled digit: the next index equals the current one. This counts as a wrap, so `frame_tick` pulses every BLANK+DIG cycles.
- `digit_mask` is sampled only at digit advance. A change to the currently shown digit's bit takes effect at the next advance.
- m becomes 0 while running: at the next advance go to IDLE. `enable`=0 in any state: IDLE next cycle, outputs inactive next cycle, `sel`=0.
- ACTIVE_LOW=1: `an`/`seg` outputs are inverted versus internal active-high values. `mux_in` is assumed active-high (segment on = 1).

## Timing
- Reset values: state IDLE, `sel`=0, `cnt`=0, `frame_tick`=0. `an` = 8'hFF and `seg` = 7'h7F when ACTIVE_LOW=1; all zeros when ACTIVE_LOW=0.
- `rst` mid-scan: all outputs at reset values on the cycle after `rst` is sampled high. `rst` has priority over `enable`.
- IDLE→BLANK entry: the cycle after `enable` is sampled high.
- `sel` changes only on entry to BLANK, so the mux path has ≥BLANK_CYCLES cycles to settle before `an` asserts.
- `an` and `seg` go active in the same cycle, the first SHOW cycle. Both go inactive in the first BLANK cycle.
- Per-digit period is BLANK_CYCLES + DIG_CYCLES. Frame period is k·(BLANK_CYCLES+DIG_CYCLES) for k enabled digits.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package `seg_pkg`: state enum (IDLE/BLANK/SHOW), digit-index width (3), segment width (7), inactive-level helper constants.
- One sub-module `seg_scan_next_idx`: combinational. Given 8-bit mask and current index, returns the next set index with wrap plus a `wrapped` flag. It is reused for the IDLE start search (current = 7).
- `cnt`, FSM and output registers live in the top.

## Test plan
Bench parameters: DIG_CYCLES=4, BLANK_CYCLES=2, ACTIVE_LOW=1, NUM_DIGITS=8.
- Reset with `enable`=1 held → `an`=8'hFF, `seg`=7'h7F, `sel`=0 while `rst`=1. First `frame_tick` 1 cycle after release.
- mask=8'hFF, `mux_in` driven by a model of the mux from `sel` → `sel` sequence 0..7,0. Each `an` low-bit is held 4 cycles with 2-cycle all-high gap. `frame_tick` period = 48 cycles.
- mask=8'b1000_0101 → `sel` visits 0,2,7,0. Frame period 18 cycles. `an` never asserts bits 1,3–6.
- mask=8'h10, `mux_in`=7'h3F → `an`=8'hEF for 4 of every 6 cycles and `seg`=7'h40 in SHOW. `frame_tick` pulses every 6 cycles.
- mask→8'h00 mid-SHOW of digit 3 → digit 3 completes its 4 cycles, then IDLE with outputs inactive. Restoring mask=8'h01 → BLANK next cycle, `sel`=0.
- `enable` dropped mid-BLANK, and separately `rst` pulsed mid-SHOW → next cycle `an`=8'hFF, `seg`=7'h7F, `sel`=0. Restart begins at lowest enabled digit.
